// File: rtl/memShare_config_pkg.sv
// memShare controller configuration shared with the message-pass datapath.
package memShare_config_pkg;

    localparam int unsigned MEMSHARE_DRC_NUM = 2;

endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass buffer configuration: read scheduler defaults, state encoding and error bits.
package msgPass_config_pkg;

    localparam int unsigned MSGPASS_LEN_WIDTH = 6;
    localparam int unsigned MSGPASS_LAYER_NUM = 4;

    localparam int unsigned ERR_START_BUSY = 0;
    localparam int unsigned ERR_ZERO_LEN   = 1;
    localparam int unsigned ERR_WIDTH      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEGIN = 2'd1,
        ST_READ  = 2'd2,
        ST_END   = 2'd3
    } msgpass_rd_sched_state_t;

endpackage

// File: rtl/layer_idx_cnt.sv
// Layer index within one decoding iteration: modulo-LAYER_NUM counter with wrap flag.
module layer_idx_cnt #(
    parameter int unsigned LAYER_NUM   = 4,
    parameter int unsigned LAYER_WIDTH = $clog2(LAYER_NUM)
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   inc_i,
    output logic [LAYER_WIDTH-1:0] idx_o,
    output logic                   wrap_o
);

    logic [LAYER_WIDTH-1:0] idx_q, idx_d;
    logic                   at_max;

    assign at_max = (idx_q == LAYER_WIDTH'(LAYER_NUM - 1));
    assign wrap_o = inc_i && at_max;
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (inc_i) begin
            idx_d = at_max ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/msgpass_rd_sched.sv
// Layer-level read scheduler: frames each layer's reads with begin/end pulses for the
// buffer read address generator and gates the memShare DRC select onto valid reads.
module msgpass_rd_sched
    import msgPass_config_pkg::*;
#(
    parameter int unsigned LEN_WIDTH   = MSGPASS_LEN_WIDTH,
    parameter int unsigned LAYER_NUM   = MSGPASS_LAYER_NUM,
    parameter int unsigned LAYER_WIDTH = $clog2(LAYER_NUM),
    parameter int unsigned DRC_NUM     = memShare_config_pkg::MEMSHARE_DRC_NUM
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   layer_start_i,
    input  logic [LEN_WIDTH-1:0]   layer_len_i,
    input  logic [DRC_NUM-1:0]     drc_i,
    input  logic                   abort_i,
    input  logic                   err_clr_i,
    output logic                   buffer_read_begin_o,
    output logic                   buffer_read_end_o,
    output logic [DRC_NUM-1:0]     is_drc_o,
    output logic                   rd_valid_o,
    output logic [LEN_WIDTH-1:0]   rd_idx_o,
    output logic [LAYER_WIDTH-1:0] layer_idx_o,
    output logic                   busy_o,
    output logic                   layer_done_o,
    output logic                   iter_done_o,
    output logic                   aborted_o,
    output logic [1:0]             err_o
);

    msgpass_rd_sched_state_t state_q, state_d;

    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                 abort_q, abort_d;
    logic [ERR_WIDTH-1:0] err_q, err_d, err_set;
    logic                 start_ok;
    logic                 layer_inc;
    logic                 layer_wrap;

    assign start_ok = layer_start_i && (layer_len_i != '0);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            rd_cnt_q <= '0;
            abort_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        abort_d  = abort_q;
        err_set  = '0;
        unique case (state_q)
            // END accepts a new start exactly like IDLE, giving back-to-back layers.
            ST_IDLE, ST_END: begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    len_d    = layer_len_i;
                    rd_cnt_d = '0;
                    abort_d  = 1'b0;
                    state_d  = ST_BEGIN;
                end else if (layer_start_i) begin
                    err_set[ERR_ZERO_LEN] = 1'b1;
                end
            end
            ST_BEGIN: begin
                if (layer_start_i) begin
                    err_set[ERR_START_BUSY] = 1'b1;
                end
                if (abort_i) begin
                    abort_d = 1'b1;
                    state_d = ST_END;
                end else if (len_q > LEN_WIDTH'(1)) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_END;
                end
            end
            ST_READ: begin
                if (layer_start_i) begin
                    err_set[ERR_START_BUSY] = 1'b1;
                end
                if (abort_i) begin
                    abort_d = 1'b1;
                    state_d = ST_END;
                end else if (rd_cnt_q == len_q - 1'b1) begin
                    state_d = ST_END;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = (err_clr_i ? '0 : err_q) | err_set;
    end

    always_comb begin
        buffer_read_begin_o = (state_q == ST_BEGIN);
        buffer_read_end_o   = (state_q == ST_END);
        rd_valid_o          = (state_q == ST_BEGIN) || (state_q == ST_READ);
        busy_o              = (state_q != ST_IDLE);
        layer_done_o        = (state_q == ST_END) && !abort_q;
        aborted_o           = (state_q == ST_END) && abort_q;
        rd_idx_o            = rd_valid_o ? rd_cnt_q : '0;
        is_drc_o            = rd_valid_o ? drc_i : '0;
        err_o               = err_q;
    end

    assign layer_inc   = layer_done_o;
    assign iter_done_o = layer_wrap;

    layer_idx_cnt #(
        .LAYER_NUM   (LAYER_NUM),
        .LAYER_WIDTH (LAYER_WIDTH)
    ) u_layer_idx_cnt (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .inc_i   (layer_inc),
        .idx_o   (layer_idx_o),
        .wrap_o  (layer_wrap)
    );

endmodule

// File: tb/tb_msgpass_rd_sched.sv
// Bench for msgpass_rd_sched: read beats are scoreboarded against a stand-in address generator.
module tb_msgpass_rd_sched;

    localparam int LW  = 6;
    localparam int NL  = 4;
    localparam int LYW = 2;
    localparam int DN  = 2;

    logic           sys_clk = 1'b0;
    logic           rstn = 1'b0;
    logic           layer_start_i = 1'b0;
    logic [LW-1:0]  layer_len_i = '0;
    logic [DN-1:0]  drc_i = '0;
    logic           abort_i = 1'b0;
    logic           err_clr_i = 1'b0;
    logic           buffer_read_begin_o, buffer_read_end_o;
    logic [DN-1:0]  is_drc_o;
    logic           rd_valid_o;
    logic [LW-1:0]  rd_idx_o;
    logic [LYW-1:0] layer_idx_o;
    logic           busy_o, layer_done_o, iter_done_o, aborted_o;
    logic [1:0]     err_o;

    int checks = 0;
    int errors = 0;
    int exp_layer = 0;

    typedef struct {
        logic [LW-1:0] idx;
        logic [DN-1:0] drc;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_b;

    logic [6:0]  ctl;
    logic [18:0] all_out;
    logic [LW-1:0] gen_cnt_q;
    logic [LW-1:0] gen_addr;

    always #5 sys_clk = ~sys_clk;

    msgpass_rd_sched #(
        .LEN_WIDTH   (LW),
        .LAYER_NUM   (NL),
        .LAYER_WIDTH (LYW),
        .DRC_NUM     (DN)
    ) dut (
        .sys_clk             (sys_clk),
        .rstn                (rstn),
        .layer_start_i       (layer_start_i),
        .layer_len_i         (layer_len_i),
        .drc_i               (drc_i),
        .abort_i             (abort_i),
        .err_clr_i           (err_clr_i),
        .buffer_read_begin_o (buffer_read_begin_o),
        .buffer_read_end_o   (buffer_read_end_o),
        .is_drc_o            (is_drc_o),
        .rd_valid_o          (rd_valid_o),
        .rd_idx_o            (rd_idx_o),
        .layer_idx_o         (layer_idx_o),
        .busy_o              (busy_o),
        .layer_done_o        (layer_done_o),
        .iter_done_o         (iter_done_o),
        .aborted_o           (aborted_o),
        .err_o               (err_o)
    );

    assign ctl = {buffer_read_begin_o, rd_valid_o, buffer_read_end_o, layer_done_o,
                  iter_done_o, aborted_o, busy_o};
    assign all_out = {buffer_read_begin_o, buffer_read_end_o, is_drc_o, rd_valid_o, rd_idx_o,
                      layer_idx_o, busy_o, layer_done_o, iter_done_o, aborted_o, err_o};

    // Stand-in generator: increment forced to 0 on begin, so the first address is base (0).
    always @(posedge sys_clk or negedge rstn) begin
        if (!rstn) gen_cnt_q <= '0;
        else if (buffer_read_begin_o) gen_cnt_q <= LW'(1);
        else if (rd_valid_o) gen_cnt_q <= gen_cnt_q + 1'b1;
    end
    assign gen_addr = buffer_read_begin_o ? '0 : gen_cnt_q;

    always @(negedge sys_clk) begin
        if (rstn) begin
            checks++;
            if (rd_valid_o) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected rd_idx=%0d required no read", rd_idx_o);
                end else begin
                    mon_b = exp_q.pop_front();
                    if ({rd_idx_o, is_drc_o, gen_addr} !== {mon_b.idx, mon_b.drc, mon_b.idx}) begin
                        errors++;
                        $display("FAIL beat idx/drc/addr got %0d/%b/%0d required %0d/%b/%0d",
                                 rd_idx_o, is_drc_o, gen_addr, mon_b.idx, mon_b.drc, mon_b.idx);
                    end
                end
            end else if (is_drc_o !== '0) begin
                errors++;
                $display("FAIL drc_idle is_drc=%b required 00", is_drc_o);
            end
        end
    end

    function automatic logic [6:0] exp_ctl(input int c, input int len, input int layer);
        logic e;
        e = (c == len + 1);
        return {c == 1, (c >= 1) && (c <= len), e, e, e && (layer == NL - 1), 1'b0,
                (c >= 1) && (c <= len + 1)};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", all_out);
        end
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        exp_layer = 0;
    endtask

    task automatic test_single_layer(input int len);
        int li;
        li = exp_layer;
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = LW'(len);
        for (int i = 0; i < len; i++) exp_q.push_back('{LW'(i), '0});
        for (int c = 0; c <= len + 1; c++) begin
            if (c > 0) begin
                tick();
                layer_start_i = 1'b0;
            end
            @(negedge sys_clk);
            checks++;
            if (ctl !== exp_ctl(c, len, li)) begin
                errors++;
                $display("FAIL single_ctl L=%0d c=%0d got %b required %b", len, c, ctl, exp_ctl(c, len, li));
            end
            if (c == len + 1) begin
                checks++;
                if (layer_idx_o !== LYW'(li)) begin
                    errors++;
                    $display("FAIL single_layer_in_end got %0d required %0d", layer_idx_o, li);
                end
            end
        end
        exp_layer = (li + 1) % NL;
        tick();
        @(negedge sys_clk);
        checks++;
        if ({layer_idx_o, busy_o} !== {LYW'(exp_layer), 1'b0}) begin
            errors++;
            $display("FAIL single_after layer/busy got %0d/%b required %0d/0", layer_idx_o, busy_o, exp_layer);
        end
    endtask

    task automatic test_back_to_back();
        int li0, li;
        li0 = exp_layer;
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = LW'(2);
        for (int k = 0; k < 4; k++) begin
            li = (li0 + k) % NL;
            exp_q.push_back('{LW'(0), '0});
            exp_q.push_back('{LW'(1), '0});
            for (int c = 1; c <= 3; c++) begin
                tick();
                layer_start_i = (c == 3) && (k < 3);
                @(negedge sys_clk);
                checks++;
                if (ctl !== exp_ctl(c, 2, li)) begin
                    errors++;
                    $display("FAIL b2b_ctl k=%0d c=%0d got %b required %b", k, c, ctl, exp_ctl(c, 2, li));
                end
                if (c == 3) begin
                    checks++;
                    if (layer_idx_o !== LYW'(li)) begin
                        errors++;
                        $display("FAIL b2b_layer k=%0d got %0d required %0d", k, layer_idx_o, li);
                    end
                end
            end
        end
        exp_layer = (li0 + 4) % NL;
        tick();
        @(negedge sys_clk);
        checks++;
        if ({layer_idx_o, busy_o, buffer_read_begin_o} !== {LYW'(exp_layer), 2'b00}) begin
            errors++;
            $display("FAIL b2b_after layer/busy/begin got %0d/%b/%b required %0d/0/0",
                     layer_idx_o, busy_o, buffer_read_begin_o, exp_layer);
        end
    endtask

    task automatic test_drc();
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = LW'(4);
        drc_i         = 2'b11;
        exp_q.push_back('{LW'(0), 2'b00});
        exp_q.push_back('{LW'(1), 2'b01});
        exp_q.push_back('{LW'(2), 2'b00});
        exp_q.push_back('{LW'(3), 2'b00});
        @(negedge sys_clk);
        checks++;
        if (is_drc_o !== 2'b00) begin
            errors++;
            $display("FAIL drc_before got %b required 00", is_drc_o);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            layer_start_i = 1'b0;
            drc_i = (c == 2) ? 2'b01 : ((c == 5) ? 2'b11 : 2'b00);
            @(negedge sys_clk);
            if (c == 2) begin
                checks++;
                if (is_drc_o !== 2'b01) begin
                    errors++;
                    $display("FAIL drc_idx1 got %b required 01", is_drc_o);
                end
            end
            if (c == 5) begin
                checks++;
                if ({buffer_read_end_o, is_drc_o} !== 3'b100) begin
                    errors++;
                    $display("FAIL drc_end end/drc got %b/%b required 1/00", buffer_read_end_o, is_drc_o);
                end
            end
        end
        exp_layer = (exp_layer + 1) % NL;
        tick();
        drc_i = 2'b00;
    endtask

    task automatic test_abort();
        int li;
        li = exp_layer;
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = LW'(6);
        for (int i = 0; i < 3; i++) exp_q.push_back('{LW'(i), '0});
        for (int c = 1; c <= 4; c++) begin
            tick();
            layer_start_i = 1'b0;
            abort_i = (c == 3);
            @(negedge sys_clk);
            if (c == 4) begin
                checks++;
                if ({buffer_read_end_o, aborted_o, layer_done_o, iter_done_o, layer_idx_o} !== {4'b1100, LYW'(li)}) begin
                    errors++;
                    $display("FAIL abort_end end/abt/done/iter/layer got %b%b%b%b/%0d required 1100/%0d",
                             buffer_read_end_o, aborted_o, layer_done_o, iter_done_o, layer_idx_o, li);
                end
            end
        end
        tick();
        @(negedge sys_clk);
        checks++;
        if ({busy_o, aborted_o, layer_idx_o} !== {2'b00, LYW'(li)}) begin
            errors++;
            $display("FAIL abort_after busy/abt/layer got %b/%b/%0d required 0/0/%0d", busy_o, aborted_o, layer_idx_o, li);
        end
    endtask

    task automatic test_errors();
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        layer_start_i = 1'b1;
        layer_len_i   = LW'(4);
        for (int i = 0; i < 4; i++) exp_q.push_back('{LW'(i), '0});
        @(negedge sys_clk);
        checks++;
        if (err_o !== 2'b00) begin
            errors++;
            $display("FAIL err_cleared got %b required 00", err_o);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            layer_start_i = (c == 2);
            @(negedge sys_clk);
            if (c == 3) begin
                checks++;
                if (err_o !== 2'b01) begin
                    errors++;
                    $display("FAIL err_start_busy got %b required 01", err_o);
                end
            end
            if (c == 5) begin
                checks++;
                if ({buffer_read_end_o, layer_done_o} !== 2'b11) begin
                    errors++;
                    $display("FAIL err_seq_end end/done got %b%b required 11", buffer_read_end_o, layer_done_o);
                end
            end
        end
        exp_layer = (exp_layer + 1) % NL;
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = '0;
        tick();
        layer_start_i = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({err_o, busy_o, buffer_read_begin_o} !== 4'b1100) begin
            errors++;
            $display("FAIL err_zero_len err/busy/begin got %b/%b/%b required 11/0/0", err_o, busy_o, buffer_read_begin_o);
        end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (err_o !== 2'b00) begin
            errors++;
            $display("FAIL err_clr got %b required 00", err_o);
        end
        layer_start_i = 1'b1;
        err_clr_i     = 1'b1;
        tick();
        layer_start_i = 1'b0;
        err_clr_i     = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (err_o !== 2'b10) begin
            errors++;
            $display("FAIL err_set_wins got %b required 10", err_o);
        end
        layer_len_i = LW'(1);
    endtask

    task automatic test_reset_mid_read();
        tick();
        layer_start_i = 1'b1;
        layer_len_i   = LW'(5);
        for (int i = 0; i < 5; i++) exp_q.push_back('{LW'(i), '0});
        tick();
        layer_start_i = 1'b0;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_read got %h required 0", all_out);
        end
        exp_q.delete();
        exp_layer = 0;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_release got %h required 0", all_out);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_layer(3);
        test_single_layer(1);
        test_single_layer(63);
        test_drc();
        test_abort();
        test_errors();
        test_reset_mid_read();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL beats_missing got %0d outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msgpass_rd_sched.md
# msgpass_rd_sched

Layer-level read scheduler for the message-pass buffer read address generator. On each accepted layer start it emits the generator's `buffer_read_begin` pulse and qualifies a fixed number of read cycles. During those reads it forwards the memShare DRC (decoding request conflict) select. It then emits the `buffer_read_end` pulse, which freezes the generator's gated clock. The block sits between the layered-decoder control and the address generator, and also tracks the layer index within one decoding iteration.

## Interface
- `LEN_WIDTH`, default 6: width of the per-layer read count.
- `LAYER_NUM`, default 4: layers per decoding iteration.
- `LAYER_WIDTH`, default `$clog2(LAYER_NUM)`: width of the layer index.
- `DRC_NUM`, default `memShare_config_pkg::MEMSHARE_DRC_NUM`: number of DRC select lines.

Ports:
- `sys_clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `layer_start_i` in 1: pulse requesting one layer read sequence.
- `layer_len_i` in `LEN_WIDTH`: number of reads; sampled only when a start is accepted.
- `drc_i` in `DRC_NUM`: DRC request from the memShare controller for the current read cycle.
- `abort_i` in 1: terminate the sequence in progress.
- `err_clr_i` in 1: clear `err_o`.
- `buffer_read_begin_o` out 1: one-cycle pulse to the address generator.
- `buffer_read_end_o` out 1: one-cycle pulse to the address generator.
- `is_drc_o` out `DRC_NUM`: DRC select to the address generator.
- `rd_valid_o` out 1: the generator's address output is a valid read this cycle.
- `rd_idx_o` out `LEN_WIDTH`: read index within the layer.
- `layer_idx_o` out `LAYER_WIDTH`: current layer.
- `busy_o` out 1: a sequence is in progress.
- `layer_done_o` out 1: pulse, layer completed normally.
- `iter_done_o` out 1: pulse, last layer of the iteration completed.
- `aborted_o` out 1: pulse, sequence was aborted.
- `err_o` out 2: sticky errors; bit 0 = start while busy, bit 1 = zero-length start.

## Operation
- FSM states: IDLE, BEGIN, READ, END. All outputs reset to 0; the state resets to IDLE; all counters reset to 0.
- **IDLE**
  - `layer_start_i` with `layer_len_i` ≠ 0: latch the length into `len_q`, clear the read counter, go to BEGIN.
  - `layer_start_i` with `layer_len_i` = 0: ignored; set `err_o[1]`.
- **BEGIN** (one cycle)
  - `buffer_read_begin_o`=1 and `rd_valid_o`=1 with `rd_idx_o`=0. The generator forces its increment to 0 in this cycle, so address = base.
  - Go to READ if `len_q` > 1, else go to END.
- **READ**
  - `rd_valid_o`=1; `rd_idx_o` increments by 1 each cycle.
  - Go to END in the cycle where `rd_idx_o` = `len_q`−1.
- **END** (one cycle)
  - `buffer_read_end_o`=1.
  - On normal completion: `layer_done_o`=1; `layer_idx_o` increments, wrapping LAYER_NUM−1 → 0.
  - If the wrap occurs, `iter_done_o`=1 in the same cycle.
  - Next state: IDLE, or BEGIN if a valid `layer_start_i` is present this cycle (back-to-back start).
- **DRC forwarding:** `is_drc_o` = `drc_i` while `rd_valid_o`=1, else 0. It is combinational, so the generator sees the DRC selection in the same cycle.
- **Abort:** `abort_i` in BEGIN or READ → next state END.
  - In that END cycle `aborted_o`=1 instead of `layer_done_o`.
  - `layer_idx_o` does not advance.
  - `abort_i` in IDLE or END has no effect.
- `busy_o` = 1 in BEGIN, READ and END.
- `layer_start_i` in BEGIN or READ: ignored; set `err_o[0]`.
- **Error register:** `err_clr_i` clears both bits. If a set event and `err_clr_i` occur in the same cycle, set wins.

## Timing
- Start accepted at cycle t:
  - `buffer_read_begin_o` at t+1.
  - `rd_valid_o` high t+1 … t+L, with `rd_idx_o` = 0 … L−1.
  - `buffer_read_end_o` and `layer_done_o` at t+L+1.
- Minimum layer period is L+1 cycles when starts are issued back-to-back (start presented in the END cycle).
- `buffer_read_begin_o` and `buffer_read_end_o` are never asserted in the same cycle.
- Maximum L = 2^`LEN_WIDTH`−1; `rd_idx_o` never wraps.
- Asynchronous reset mid-sequence: immediate return to IDLE with all outputs 0. No end pulse is issued; the generator's own reset clears its latches.

## Structure
- Add to `msgPass_config_pkg`:
  - the state enum typedef `msgpass_rd_sched_state_t`;
  - the `LEN_WIDTH` default;
  - the `LAYER_NUM` default;
  - the error bit index constants `ERR_START_BUSY` = 0 and `ERR_ZERO_LEN` = 1.
- One sub-module is natural: `layer_idx_cnt`, a wrapping modulo-`LAYER_NUM` counter with `inc` input and `wrap` output.
- The FSM, read counter and error register stay in the top level.

## Test plan
- Start with L=3 at cycle 0:
  - begin pulse at 1;
  - `rd_valid_o` at 1–3 with `rd_idx_o` 0,1,2;
  - end pulse and `layer_done_o` at 4;
  - connected generator `addr_o` sequence 0,1,2.
- L=1: begin at 1, end at 2, exactly one `rd_valid_o` cycle.
- Four back-to-back layers with L=2, each start given in the previous END cycle:
  - `layer_idx_o` sequence 0→1→2→3→0;
  - `iter_done_o` only at the 4th end.
- `drc_i`=`01` during read index 1 of L=4 → `is_drc_o`=`01` only in that cycle; `is_drc_o`=0 outside reads even with `drc_i` held high.
- `abort_i` at read index 2 of L=6:
  - END next cycle with `aborted_o`=1 and `layer_done_o`=0;
  - `layer_idx_o` unchanged.
- Errors and reset:
  - start during READ → `err_o`=`01`;
  - start with L=0 → `err_o`=`11`;
  - `err_clr_i` → `00`;
  - `rstn` low mid-READ → all outputs 0 immediately.
